// File: rtl/rx_sched_pkg.sv
// Shared types and frame-info field layout for the rx frame scheduler.
package rx_sched_pkg;

    localparam int unsigned INFO_W    = 28;
    localparam int unsigned COUNT_MSB = 27;
    localparam int unsigned COUNT_LSB = 16;
    localparam int unsigned MS_MSB    = 15;
    localparam int unsigned MS_LSB    = 4;
    localparam int unsigned ACQ_MSB   = 3;
    localparam int unsigned ACQ_LSB   = 0;
    localparam int unsigned COUNT_W   = COUNT_MSB - COUNT_LSB + 1;
    localparam int unsigned MS_W      = MS_MSB - MS_LSB + 1;
    localparam int unsigned ACQ_W     = ACQ_MSB - ACQ_LSB + 1;

    typedef enum logic [5:0] {
        ST_IDLE    = 6'b000001,
        ST_LATCH   = 6'b000010,
        ST_POP     = 6'b000100,
        ST_READ    = 6'b001000,
        ST_WAIT    = 6'b010000,
        ST_PRESENT = 6'b100000
    } state_t;

    function automatic logic [COUNT_W-1:0] info_count(input logic [INFO_W-1:0] info);
        return info[COUNT_MSB:COUNT_LSB];
    endfunction

    function automatic logic [MS_W-1:0] info_ms(input logic [INFO_W-1:0] info);
        return info[MS_MSB:MS_LSB];
    endfunction

    function automatic logic [ACQ_W-1:0] info_acq(input logic [INFO_W-1:0] info);
        return info[ACQ_MSB:ACQ_LSB];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin search: first requesting channel at or after ptr, wrapping upward.
module rr_arbiter #(
    parameter int unsigned NCH = 4,
    parameter int unsigned CHW = 3
) (
    input  logic [NCH-1:0] req,
    input  logic [CHW-1:0] ptr,
    input  logic           en,
    output logic [CHW-1:0] grant,
    output logic           grant_valid
);

    int unsigned idx;

    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int unsigned i = 0; i < NCH; i++) begin
            idx = (32'(ptr) + i) % NCH;
            if (en && !grant_valid && req[idx]) begin
                grant       = CHW'(idx);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rx_frame_scheduler.sv
// Round-robin drain of completed rx frames from NCH channel FIFOs onto one
// tagged valid/ready byte stream.
module rx_frame_scheduler
    import rx_sched_pkg::*;
#(
    parameter int unsigned NCH    = 4,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned CHW    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH-1:0]        p_frame_ready_i,
    input  logic [NCH*INFO_W-1:0] frame_info_i,
    output logic [NCH-1:0]        n_rd_frame_o,
    input  logic [NCH*8-1:0]      data_i,
    input  logic [NCH-1:0]        p_empty_i,
    output logic [NCH-1:0]        n_rd_o,
    input  logic                  enable_i,
    output logic [7:0]            out_data_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  out_sof_o,
    output logic                  out_eof_o,
    output logic [CHW-1:0]        out_chan_o,
    output logic [INFO_W-1:0]     out_info_o,
    output logic [7:0]            underrun_cnt_o
);

    state_t             state;
    logic [CHW-1:0]     rr_ptr;
    logic [CHW-1:0]     grant_q;
    logic [CHW-1:0]     grant;
    logic [CHW-1:0]     ptr_next;
    logic               grant_valid;
    logic               arb_en;
    logic [COUNT_W-1:0] remain;
    logic               first_byte;
    logic [1:0]         wait_cnt;
    logic [INFO_W-1:0]  info_sel;
    logic [7:0]         data_sel;

    assign arb_en   = enable_i && (state == ST_IDLE);
    assign info_sel = frame_info_i[INFO_W*32'(grant_q) +: INFO_W];
    assign data_sel = data_i[8*32'(grant_q) +: 8];
    assign ptr_next = (grant == CHW'(NCH-1)) ? '0 : grant + CHW'(1);

    // Strobe decoded in READ itself so data lands exactly RD_LAT cycles later, at the end of WAIT.
    assign n_rd_o = ((state == ST_READ) && !p_empty_i[grant_q]) ? ~(NCH'(1) << grant_q) : '1;

    rr_arbiter #(
        .NCH (NCH),
        .CHW (CHW)
    ) u_arb (
        .req         (p_frame_ready_i),
        .ptr         (rr_ptr),
        .en          (arb_en),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ST_IDLE;
            rr_ptr         <= '0;
            grant_q        <= '0;
            remain         <= '0;
            first_byte     <= 1'b0;
            wait_cnt       <= '0;
            n_rd_frame_o   <= '1;
            out_valid_o    <= 1'b0;
            out_sof_o      <= 1'b0;
            out_eof_o      <= 1'b0;
            out_data_o     <= '0;
            out_chan_o     <= '0;
            out_info_o     <= '0;
            underrun_cnt_o <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        grant_q <= grant;
                        rr_ptr  <= ptr_next;
                        state   <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    out_info_o   <= info_sel;
                    out_chan_o   <= grant_q;
                    remain       <= info_count(info_sel);
                    first_byte   <= 1'b1;
                    n_rd_frame_o <= ~(NCH'(1) << grant_q);
                    state        <= ST_POP;
                end
                ST_POP: begin
                    n_rd_frame_o <= '1;
                    if (remain == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        state <= ST_READ;
                    end
                end
                ST_READ: begin
                    // An empty FIFO mid-frame aborts without EOF; the counter saturates.
                    if (p_empty_i[grant_q]) begin
                        if (underrun_cnt_o != 8'hFF) begin
                            underrun_cnt_o <= underrun_cnt_o + 8'd1;
                        end
                        state <= ST_IDLE;
                    end else begin
                        wait_cnt <= '0;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 2'(RD_LAT-1)) begin
                        out_data_o  <= data_sel;
                        out_valid_o <= 1'b1;
                        out_sof_o   <= first_byte;
                        out_eof_o   <= (remain == COUNT_W'(1));
                        state       <= ST_PRESENT;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                ST_PRESENT: begin
                    if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                        out_sof_o   <= 1'b0;
                        out_eof_o   <= 1'b0;
                        first_byte  <= 1'b0;
                        remain      <= remain - COUNT_W'(1);
                        if (remain == COUNT_W'(1)) begin
                            state <= ST_IDLE;
                        end else begin
                            state <= ST_READ;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_frame_scheduler.sv
// Directed bench for rx_frame_scheduler: queue-based channel FIFO model plus
// a stream scoreboard filled when frames are loaded.
module tb_rx_frame_scheduler;
    import rx_sched_pkg::*;

    localparam int NCH    = 4;
    localparam int RD_LAT = 1;
    localparam int CHW    = 3;

    typedef struct packed {
        logic [7:0]     data;
        logic           sof;
        logic           eof;
        logic [CHW-1:0] chan;
        logic [27:0]    info;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NCH-1:0]    p_frame_ready_i = '0;
    logic [NCH*28-1:0] frame_info_i = '0;
    logic [NCH-1:0]    n_rd_frame_o;
    logic [NCH*8-1:0]  data_i;
    logic [NCH-1:0]    p_empty_i = '1;
    logic [NCH-1:0]    n_rd_o;
    logic              enable_i = 1'b0;
    logic [7:0]        out_data_o;
    logic              out_valid_o;
    logic              out_ready_i = 1'b1;
    logic              out_sof_o;
    logic              out_eof_o;
    logic [CHW-1:0]    out_chan_o;
    logic [27:0]       out_info_o;
    logic [7:0]        underrun_cnt_o;

    beat_t       expq[$];
    logic [7:0]  fifo[NCH][$];
    logic [27:0] infq[NCH][$];
    logic [7:0]  dreg[NCH];
    int          rd_cnt[NCH];
    int          rdf_cnt[NCH];
    logic        rd_empty_err = 1'b0;
    int          vectors = 0;
    int          miscompares = 0;
    int unsigned stamp = 1;
    beat_t       mon_obs;
    beat_t       mon_exp;

    always #5 clk = ~clk;

    rx_frame_scheduler #(.NCH(NCH), .RD_LAT(RD_LAT), .CHW(CHW)) dut (
        .clk(clk), .rst(rst),
        .p_frame_ready_i(p_frame_ready_i), .frame_info_i(frame_info_i),
        .n_rd_frame_o(n_rd_frame_o), .data_i(data_i), .p_empty_i(p_empty_i),
        .n_rd_o(n_rd_o), .enable_i(enable_i),
        .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_sof_o(out_sof_o), .out_eof_o(out_eof_o), .out_chan_o(out_chan_o),
        .out_info_o(out_info_o), .underrun_cnt_o(underrun_cnt_o)
    );

    assign data_i = {dreg[3], dreg[2], dreg[1], dreg[0]};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Channel-side inputs follow the model queues, refreshed mid-cycle.
    always @(negedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            p_frame_ready_i[c]       = (infq[c].size() != 0);
            frame_info_i[c*28 +: 28] = (infq[c].size() != 0) ? infq[c][0] : 28'h0;
            p_empty_i[c]             = (fifo[c].size() == 0);
        end
    end

    // FIFO / frame-info pops with one-cycle read latency.
    always @(posedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (!n_rd_o[c]) begin
                rd_cnt[c] <= rd_cnt[c] + 1;
                if (fifo[c].size() != 0) dreg[c] <= fifo[c].pop_front();
                else rd_empty_err <= 1'b1;
            end
            if (!n_rd_frame_o[c]) begin
                rdf_cnt[c] <= rdf_cnt[c] + 1;
                if (infq[c].size() != 0) void'(infq[c].pop_front());
            end
        end
    end

    // Stream scoreboard and strobe exclusivity monitor.
    always @(negedge clk) begin
        if (rst) begin
            check("strobe_excl", 64'(($countones(~n_rd_o) <= 1) &&
                  !((n_rd_o != '1) && (n_rd_frame_o != '1)) && !rd_empty_err), 64'd1);
            if (out_valid_o && out_ready_i) begin
                check("stream_expected", 64'(expq.size() != 0), 64'd1);
                if (expq.size() != 0) begin
                    mon_exp = expq.pop_front();
                    mon_obs = {out_data_o, out_sof_o, out_eof_o, out_chan_o, out_info_o};
                    check("stream_beat", 64'(mon_obs), 64'(mon_exp));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load_frame(input int c, input int cnt, input int nbytes,
                              input logic [7:0] base, output logic [27:0] info);
        beat_t b;
        info = {12'(cnt), 12'(stamp), 4'(c)};
        stamp++;
        infq[c].push_back(info);
        for (int i = 0; i < nbytes; i++) begin
            fifo[c].push_back(base + 8'(i));
            if (i < cnt) begin
                b.data = base + 8'(i);
                b.sof  = (i == 0);
                b.eof  = (i == cnt - 1);
                b.chan = CHW'(c);
                b.info = info;
                expq.push_back(b);
            end
        end
    endtask

    task automatic wait_sof(input string tag);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(out_valid_o && out_sof_o) && t < 300);
        check(tag, 64'(t < 300), 64'd1);
    endtask

    task automatic wait_drain(input int left, input string tag);
        int t = 0;
        while (expq.size() != left && t < 500) begin
            @(negedge clk);
            t++;
        end
        check(tag, 64'(t < 500), 64'd1);
        repeat (10) @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_nrd"}, 64'(n_rd_o), 64'hF);
        check({tag, "_nrdf"}, 64'(n_rd_frame_o), 64'hF);
        check({tag, "_flags"}, 64'({out_valid_o, out_sof_o, out_eof_o}), 64'd0);
        check({tag, "_data"}, 64'({out_data_o, out_chan_o, out_info_o}), 64'd0);
        check({tag, "_underrun"}, 64'(underrun_cnt_o), 64'd0);
        check({tag, "_ptr"}, 64'(dut.rr_ptr), 64'd0);
    endtask

    initial begin
        logic [27:0] info;
        logic [27:0] dummy;
        int b_rd, b_rdf, b_rd0, lat, gap, t;

        #1 rst = 1'b0;
        enable_i = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check_reset_state("reset");
        rst = 1'b1;

        // Single frame on ch2: latency, throughput, strobe counts, tags.
        tick();
        b_rd = rd_cnt[2];
        b_rdf = rdf_cnt[2];
        load_frame(2, 3, 3, 8'hA1, info);
        lat = 0;
        @(negedge clk);
        while (!out_valid_o && lat < 50) begin
            lat++;
            @(negedge clk);
        end
        check("first_latency", 64'(lat), 64'(4 + RD_LAT));
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (!out_valid_o && gap < 50);
        check("byte_period", 64'(gap), 64'(2 + RD_LAT));
        wait_drain(0, "single_drain");
        check("single_rdf", 64'(rdf_cnt[2] - b_rdf), 64'd1);
        check("single_rd", 64'(rd_cnt[2] - b_rd), 64'd3);
        check("single_chan", 64'(out_chan_o), 64'd2);
        check("single_info", 64'(out_info_o), 64'(info));
        check("single_ptr", 64'(dut.rr_ptr), 64'd3);

        // Backpressure on byte 2 of 4 (ch1).
        tick();
        b_rd = rd_cnt[1];
        load_frame(1, 4, 4, 8'h10, info);
        wait_sof("bp_sof");
        tick();
        out_ready_i = 1'b0;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!out_valid_o && t < 50);
        check("bp_valid_wait", 64'(t < 50), 64'd1);
        for (int i = 0; i < 10; i++) begin
            check("bp_hold", 64'({out_valid_o, out_data_o, out_sof_o, out_eof_o, out_info_o}),
                  64'({1'b1, 8'h11, 1'b0, 1'b0, info}));
            @(negedge clk);
        end
        check("bp_no_extra_rd", 64'(rd_cnt[1] - b_rd), 64'd2);
        tick();
        out_ready_i = 1'b1;
        wait_drain(0, "bp_drain");
        check("bp_rd_total", 64'(rd_cnt[1] - b_rd), 64'd4);

        // Underrun on ch3 (count 5, only 2 bytes), then ch0 is served.
        tick();
        b_rd = rd_cnt[3];
        b_rd0 = rdf_cnt[0];
        load_frame(3, 5, 2, 8'h31, dummy);
        load_frame(0, 1, 1, 8'h40, dummy);
        wait_drain(0, "underrun_drain");
        check("underrun_cnt", 64'(underrun_cnt_o), 64'd1);
        check("underrun_rd", 64'(rd_cnt[3] - b_rd), 64'd2);
        check("underrun_next", 64'(rdf_cnt[0] - b_rd0), 64'd1);
        check("underrun_ptr", 64'(dut.rr_ptr), 64'd1);

        // Zero-length frame on ch1.
        tick();
        b_rd = rd_cnt[1];
        b_rdf = rdf_cnt[1];
        load_frame(1, 0, 0, 8'h00, dummy);
        wait_drain(0, "zero_drain");
        check("zero_rdf", 64'(rdf_cnt[1] - b_rdf), 64'd1);
        check("zero_rd", 64'(rd_cnt[1] - b_rd), 64'd0);
        check("zero_ptr", 64'(dut.rr_ptr), 64'd2);

        // Disable during byte 1 of 3 on ch2 while ch3 stays ready.
        tick();
        b_rdf = rdf_cnt[3];
        load_frame(2, 3, 3, 8'h51, dummy);
        load_frame(3, 1, 1, 8'h5A, dummy);
        wait_sof("dis_sof");
        tick();
        enable_i = 1'b0;
        wait_drain(1, "dis_drain");
        repeat (20) @(negedge clk);
        check("dis_no_grant", 64'(rdf_cnt[3] - b_rdf), 64'd0);
        check("dis_idle_valid", 64'(out_valid_o), 64'd0);
        tick();
        enable_i = 1'b1;
        wait_drain(0, "reen_drain");
        check("reen_grant", 64'(rdf_cnt[3] - b_rdf), 64'd1);

        // Asynchronous reset mid-frame on ch0.
        tick();
        load_frame(0, 4, 4, 8'h70, dummy);
        wait_sof("rst_sof");
        tick();
        rst = 1'b0;
        #1;
        check_reset_state("midrst");
        fifo[0].delete();
        expq.delete();
        repeat (3) tick();
        rst = 1'b1;

        // Round robin from pointer 0, ch0 holding a second frame.
        tick();
        load_frame(0, 1, 1, 8'h60, dummy);
        load_frame(1, 1, 1, 8'h61, dummy);
        load_frame(2, 1, 1, 8'h62, dummy);
        load_frame(3, 1, 1, 8'h63, dummy);
        load_frame(0, 1, 1, 8'h64, dummy);
        wait_drain(0, "rr_drain");
        check("rr_ptr_wrap", 64'(dut.rr_ptr), 64'd1);
        check("rr_all_served", 64'(infq[0].size() + infq[1].size() + infq[2].size() + infq[3].size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rx_frame_scheduler.md
Name: rx_frame_scheduler

Overview:
- Shares one host-side byte stream between NCH receive channels. Each channel has its own rx byte FIFO and frame-info register.
- Selects channels with completed frames in round-robin order, latches the frame info, and drains exactly that many bytes from the channel FIFO.
- Each drained byte is presented on a valid/ready stream, tagged with channel, start-of-frame and end-of-frame.
- Sits between the per-channel receive cores and the host bus interface / DMA.

Parameters:
- NCH, 4: number of receive channels, 2..8.
- RD_LAT, 1: clk cycles from the n_rd_o low pulse to valid FIFO data_i, 1..3.
- CHW, 3: width of channel index; must satisfy 2^CHW >= NCH.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- p_frame_ready_i  in  NCH  channel c has at least one completed frame (frame info valid).
- frame_info_i  in  NCH*28  per-channel frame info. Fields: [27:16] byte count, [15:4] ms stamp, [3:0] 0.1 ms stamp.
- n_rd_frame_o  out  NCH  per-channel frame-info pop, active-low, one-cycle pulse.
- data_i  in  NCH*8  per-channel rx FIFO output.
- p_empty_i  in  NCH  per-channel rx FIFO empty.
- n_rd_o  out  NCH  per-channel FIFO read, active-low, one-cycle pulse.
- enable_i  in  1  scheduler enable. When low, no new grant is issued; the current frame completes.
- out_data_o  out  8  stream byte.
- out_valid_o  out  1  stream byte valid.
- out_ready_i  in  1  host accepts byte.
- out_sof_o  out  1  first byte of frame, qualified by out_valid_o.
- out_eof_o  out  1  last byte of frame, qualified by out_valid_o.
- out_chan_o  out  CHW  source channel of the current frame.
- out_info_o  out  28  latched frame info of the current frame; stable from SOF through EOF.
- underrun_cnt_o  out  8  count of frames aborted because the FIFO ran empty.

Behaviour:
- Reset values:
  - n_rd_o and n_rd_frame_o all ones.
  - out_valid_o, out_sof_o, out_eof_o = 0.
  - out_data_o, out_chan_o, out_info_o, underrun_cnt_o = 0.
  - Round-robin pointer = 0.
  - FSM in IDLE.
- FSM states: IDLE, LATCH, POP, READ, WAIT, PRESENT.
- IDLE:
  - If enable_i=1 and any p_frame_ready_i is set, grant the first ready channel at or after the pointer, searching upward with wrap. Go to LATCH.
  - Pointer becomes grant+1 mod NCH.
- LATCH:
  - Register frame_info_i of the granted channel into out_info_o; set out_chan_o.
  - remain = byte count. Go to POP.
- POP:
  - Pulse n_rd_frame_o[grant] low for exactly one cycle.
  - If remain==0: the frame is discarded, no stream output, return to IDLE.
  - Otherwise go to READ.
- READ:
  - If p_empty_i[grant]=1: abort the frame. underrun_cnt_o increments, saturating at 255. No EOF is emitted. Go to IDLE.
  - Otherwise pulse n_rd_o[grant] low for one cycle and go to WAIT.
- WAIT:
  - Hold RD_LAT cycles, capture data_i[grant] into out_data_o, go to PRESENT.
- PRESENT:
  - out_valid_o=1. out_sof_o=1 iff this is the first byte of the frame. out_eof_o=1 iff remain==1.
  - On out_valid_o & out_ready_i: remain decrements.
    - If remain was 1, go to IDLE.
    - Otherwise go to READ.
  - Hold all out_* stable while out_ready_i=0.
- Timing:
  - Minimum latency from grant to first out_valid_o = 4+RD_LAT cycles.
  - Per-byte throughput = one byte every 2+RD_LAT cycles with out_ready_i held high.
  - At most one n_rd_o bit is low in any cycle; n_rd_o and n_rd_frame_o are never low in the same cycle.
- Simultaneous p_frame_ready_i: strict round-robin. A channel with a continuously ready frame is served at most every NCH grants.
- p_frame_ready_i changes of non-granted channels during a frame are ignored until IDLE.
- enable_i falling mid-frame does not abort; the frame completes, then the FSM stays in IDLE.
- Byte count is 12 bits and remain is 12 bits. Count 4095 must be supported without wrap.
- Asynchronous reset mid-frame returns everything to reset values immediately. Channel FIFOs are not flushed by this block.

Decomposition:
- Shared package rx_sched_pkg holds:
  - state encodings (one-hot, 6 bits);
  - frame_info field offsets (COUNT_MSB=27, COUNT_LSB=16, MS_MSB=15, MS_LSB=4, ACQ_MSB=3, ACQ_LSB=0);
  - the 28-bit info width constant.
- One sub-module: rr_arbiter. Inputs: req[NCH], ptr, en. Outputs: grant index, grant_valid. Purely combinational search plus registered pointer update.

Test Plan:
- Reset/idle: assert rst=0 mid-traffic, then release. All n_rd* are high, out_valid_o=0, underrun_cnt_o=0, pointer=0.
- Single frame:
  - Stimulus: ch2 has info count=3, bytes 0xA1,0xA2,0xA3; out_ready_i=1.
  - Required: exactly one n_rd_frame_o[2] pulse and three n_rd_o[2] pulses.
  - Stream 0xA1(sof), 0xA2, 0xA3(eof); out_chan_o=2; out_info_o equals the info.
- Round-robin: all 4 channels ready with 1-byte frames continuously. Grant order is 0,1,2,3,0. Pointer wraps correctly.
- Backpressure: out_ready_i=0 for 10 cycles on byte 2 of 4. out_data_o and flags are held stable, with no extra n_rd_o pulse. The frame completes after ready returns.
- Underrun: info count=5 but FIFO empties after 2 bytes. The stream shows 2 bytes with no eof, underrun_cnt_o=1, and the scheduler returns to IDLE and serves the next channel.
- Zero-length and disable:
  - Count=0 frame: n_rd_frame_o pulse only, no stream output.
  - enable_i=0 asserted at byte 1 of 3: the frame finishes, and no new grant occurs while a channel remains ready.
